// File: rtl/reorder_buffer_pkg.sv
// Shared reorder-buffer types and constants, also used by register read and execute
// so that the rob_idx carried down the pipe has a single definition.
package reorder_buffer_pkg;

  localparam int ROB_DEPTH = 8;
  localparam int ROB_IDX_W = 3;
  localparam int ROB_RD_W  = 7;
  localparam int ROB_XLEN  = 32;

  typedef logic [ROB_IDX_W-1:0] rob_idx_t;

  typedef struct packed {
    logic                valid;
    logic                done;
    logic                is_store;
    logic [ROB_RD_W-1:0] rd;
    logic [ROB_XLEN-1:0] pc;
    logic [ROB_XLEN-1:0] data;
  } rob_entry_t;

  // Age is the modulo-DEPTH distance from head; larger distance means younger.
  function automatic logic is_younger(input rob_idx_t idx,
                                      input rob_idx_t ref_idx,
                                      input rob_idx_t head_idx);
    rob_idx_t idx_dist;
    rob_idx_t ref_dist;
    idx_dist = idx - head_idx;
    ref_dist = ref_idx - head_idx;
    return idx_dist > ref_dist;
  endfunction

endpackage

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocate at dispatch, collect writeback/store completions,
// retire one entry per cycle from head, and squash younger entries on a mispredict.
module reorder_buffer
  import reorder_buffer_pkg::*;
#(
  parameter int DEPTH = ROB_DEPTH,
  parameter int IDX_W = ROB_IDX_W,
  parameter int RD_W  = ROB_RD_W,
  parameter int XLEN  = ROB_XLEN
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dp_valid,
  output logic             dp_ready,
  input  logic [RD_W-1:0]  dp_rd,
  input  logic [XLEN-1:0]  dp_pc,
  input  logic             dp_is_store,
  output logic [IDX_W-1:0] dp_rob_idx,
  input  logic             wb_valid,
  input  logic [IDX_W-1:0] wb_rob_idx,
  input  logic [XLEN-1:0]  wb_data,
  input  logic             st_done_valid,
  input  logic [IDX_W-1:0] st_done_rob_idx,
  input  logic             mispredict,
  input  logic [IDX_W-1:0] mis_rob_idx,
  output logic             cm_valid,
  output logic [IDX_W-1:0] cm_rob_idx,
  output logic [RD_W-1:0]  cm_rd,
  output logic [XLEN-1:0]  cm_data,
  output logic [XLEN-1:0]  cm_pc,
  output logic             cm_is_store,
  output logic             full,
  output logic             empty
);

  localparam logic [IDX_W:0] FULL_COUNT = (IDX_W+1)'(DEPTH);

  rob_entry_t       entries [DEPTH];
  logic [IDX_W-1:0] head;
  logic [IDX_W-1:0] tail;
  logic [IDX_W:0]   count;

  logic             dp_fire;
  logic [IDX_W-1:0] mis_dist;
  logic [IDX_W:0]   flush_count;
  logic [DEPTH-1:0] squash;
  logic [DEPTH-1:0] wb_hit;
  logic [DEPTH-1:0] st_hit;
  logic [DEPTH-1:0] retire;
  logic [DEPTH-1:0] alloc;

  assign full       = (count == FULL_COUNT);
  assign empty      = (count == '0);
  assign dp_ready   = !full && !mispredict;
  assign dp_fire    = dp_valid && dp_ready;
  assign dp_rob_idx = tail;

  // Commit looks only at registered state, so a writeback lands one cycle before retiring.
  assign cm_valid    = entries[head].valid && entries[head].done;
  assign cm_rob_idx  = head;
  assign cm_rd       = entries[head].rd;
  assign cm_data     = entries[head].data;
  assign cm_pc       = entries[head].pc;
  assign cm_is_store = entries[head].is_store;

  assign mis_dist    = mis_rob_idx - head;
  assign flush_count = (IDX_W+1)'(mis_dist) + (IDX_W+1)'(1) - (IDX_W+1)'(cm_valid);

  // NOTE: every output of this block gets a default before the loop so no latch is inferred.
  always_comb begin
    squash = '0;
    wb_hit = '0;
    st_hit = '0;
    retire = '0;
    alloc  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      squash[i] = mispredict && is_younger(IDX_W'(i), mis_rob_idx, head);
      wb_hit[i] = wb_valid && (wb_rob_idx == IDX_W'(i)) && entries[i].valid && !squash[i];
      st_hit[i] = st_done_valid && (st_done_rob_idx == IDX_W'(i)) && entries[i].valid
                  && !squash[i];
      retire[i] = cm_valid && (head == IDX_W'(i));
      alloc[i]  = dp_fire && (tail == IDX_W'(i));
    end
  end

  // NOTE: only valid/done are reset; payload fields are don't-care until valid is set,
  // so they carry no reset and simply hold while rst is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries[i].valid <= 1'b0;
        entries[i].done  <= 1'b0;
      end
    end else begin
      if (cm_valid) begin
        head <= head + IDX_W'(1);
      end

      if (mispredict) begin
        tail  <= mis_rob_idx + IDX_W'(1);
        count <= flush_count;
      end else begin
        if (dp_fire) begin
          tail <= tail + IDX_W'(1);
        end
        count <= count + (IDX_W+1)'(dp_fire) - (IDX_W+1)'(cm_valid);
      end

      // Allocation never collides with squash (blocked by mispredict) or retire (blocked when full).
      for (int i = 0; i < DEPTH; i++) begin
        if (squash[i] || retire[i]) begin
          entries[i].valid <= 1'b0;
          entries[i].done  <= 1'b0;
        end else if (alloc[i]) begin
          entries[i].valid    <= 1'b1;
          entries[i].done     <= 1'b0;
          entries[i].is_store <= dp_is_store;
          entries[i].rd       <= dp_rd;
          entries[i].pc       <= dp_pc;
          entries[i].data     <= '0;
        end else begin
          if (wb_hit[i] || st_hit[i]) begin
            entries[i].done <= 1'b1;
          end
          if (wb_hit[i]) begin
            entries[i].data <= wb_data;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: dispatch, out-of-order completion, in-order commit,
// full/wrap, mispredict flush, store completion and mid-run reset.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic                clk = 1'b0;
  logic                rst;
  logic                dp_valid;
  logic                dp_ready;
  logic [ROB_RD_W-1:0] dp_rd;
  logic [ROB_XLEN-1:0] dp_pc;
  logic                dp_is_store;
  logic [2:0]          dp_rob_idx;
  logic                wb_valid;
  logic [2:0]          wb_rob_idx;
  logic [ROB_XLEN-1:0] wb_data;
  logic                st_done_valid;
  logic [2:0]          st_done_rob_idx;
  logic                mispredict;
  logic [2:0]          mis_rob_idx;
  logic                cm_valid;
  logic [2:0]          cm_rob_idx;
  logic [ROB_RD_W-1:0] cm_rd;
  logic [ROB_XLEN-1:0] cm_data;
  logic [ROB_XLEN-1:0] cm_pc;
  logic                cm_is_store;
  logic                full;
  logic                empty;

  int checks = 0;
  int errors = 0;

  reorder_buffer dut (
    .clk             (clk),
    .rst             (rst),
    .dp_valid        (dp_valid),
    .dp_ready        (dp_ready),
    .dp_rd           (dp_rd),
    .dp_pc           (dp_pc),
    .dp_is_store     (dp_is_store),
    .dp_rob_idx      (dp_rob_idx),
    .wb_valid        (wb_valid),
    .wb_rob_idx      (wb_rob_idx),
    .wb_data         (wb_data),
    .st_done_valid   (st_done_valid),
    .st_done_rob_idx (st_done_rob_idx),
    .mispredict      (mispredict),
    .mis_rob_idx     (mis_rob_idx),
    .cm_valid        (cm_valid),
    .cm_rob_idx      (cm_rob_idx),
    .cm_rd           (cm_rd),
    .cm_data         (cm_data),
    .cm_pc           (cm_pc),
    .cm_is_store     (cm_is_store),
    .full            (full),
    .empty           (empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic dispatch(input logic [ROB_RD_W-1:0] rd, input logic [31:0] pc,
                          input logic st, input logic [2:0] exp_idx);
    dp_valid    = 1'b1;
    dp_rd       = rd;
    dp_pc       = pc;
    dp_is_store = st;
    #1;
    check("dp_ready", 64'(dp_ready), 64'(1));
    check("dp_rob_idx", 64'(dp_rob_idx), 64'(exp_idx));
    tick();
    dp_valid = 1'b0;
  endtask

  task automatic wb(input logic [2:0] idx, input logic [31:0] data);
    wb_valid   = 1'b1;
    wb_rob_idx = idx;
    wb_data    = data;
    tick();
    wb_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    dp_valid = 1'b0; dp_rd = '0; dp_pc = '0; dp_is_store = 1'b0;
    wb_valid = 1'b0; wb_rob_idx = '0; wb_data = '0;
    st_done_valid = 1'b0; st_done_rob_idx = '0;
    mispredict = 1'b0; mis_rob_idx = '0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_empty", 64'(empty), 64'(1));
    check("rst_full", 64'(full), 64'(0));
    check("rst_dp_ready", 64'(dp_ready), 64'(1));
    check("rst_cm_valid", 64'(cm_valid), 64'(0));
    check("rst_dp_rob_idx", 64'(dp_rob_idx), 64'(0));

    // Out-of-order completion, in-order commit
    dispatch(7'd5, 32'h100, 1'b0, 3'd0);
    dispatch(7'd6, 32'h104, 1'b0, 3'd1);
    dispatch(7'd7, 32'h108, 1'b0, 3'd2);
    check("t1_count3", 64'(dut.count), 64'(3));
    wb(3'd1, 32'hB1);
    check("t1_no_commit_idx1_first", 64'(cm_valid), 64'(0));
    wb_valid = 1'b1; wb_rob_idx = 3'd0; wb_data = 32'hA0;
    #1;
    check("t1_no_bypass", 64'(cm_valid), 64'(0));
    tick();
    wb_valid = 1'b0;
    check("t1_cm0_valid", 64'(cm_valid), 64'(1));
    check("t1_cm0_idx", 64'(cm_rob_idx), 64'(0));
    check("t1_cm0_rd", 64'(cm_rd), 64'(5));
    check("t1_cm0_data", 64'(cm_data), 64'(32'hA0));
    check("t1_cm0_pc", 64'(cm_pc), 64'(32'h100));
    tick();
    check("t1_cm1_valid", 64'(cm_valid), 64'(1));
    check("t1_cm1_idx", 64'(cm_rob_idx), 64'(1));
    check("t1_cm1_rd", 64'(cm_rd), 64'(6));
    check("t1_cm1_data", 64'(cm_data), 64'(32'hB1));
    tick();
    check("t1_idx2_pending", 64'(cm_valid), 64'(0));
    check("t1_count1", 64'(dut.count), 64'(1));

    // Fill, full back-pressure, wrap
    do_reset();
    for (int i = 0; i < 8; i++) dispatch(7'(i + 1), 32'h200 + 32'(4 * i), 1'b0, 3'(i));
    check("t2_full", 64'(full), 64'(1));
    check("t2_dp_ready_low", 64'(dp_ready), 64'(0));
    check("t2_count8", 64'(dut.count), 64'(8));
    check("t2_tail_wrapped", 64'(dp_rob_idx), 64'(0));
    dp_valid = 1'b1;
    tick();
    dp_valid = 1'b0;
    check("t2_full_rejects", 64'(dut.count), 64'(8));
    wb(3'd0, 32'hC0);
    check("t2_cm0_valid", 64'(cm_valid), 64'(1));
    check("t2_cm0_idx", 64'(cm_rob_idx), 64'(0));
    check("t2_still_full", 64'(dp_ready), 64'(0));
    tick();
    check("t2_ready_after_commit", 64'(dp_ready), 64'(1));
    check("t2_count7", 64'(dut.count), 64'(7));
    check("t2_not_full", 64'(full), 64'(0));
    dispatch(7'd9, 32'h220, 1'b0, 3'd0);
    check("t2_tail1", 64'(dp_rob_idx), 64'(1));
    check("t2_full_again", 64'(full), 64'(1));

    // Flush across the wrap: head=6, tail=3, mispredict at 7
    do_reset();
    for (int i = 0; i < 6; i++) dispatch(7'(i + 1), 32'h300 + 32'(4 * i), 1'b0, 3'(i));
    for (int i = 0; i < 6; i++) wb(3'(i), 32'(i));
    tick();
    check("t3_drained", 64'(empty), 64'(1));
    check("t3_tail6", 64'(dp_rob_idx), 64'(6));
    for (int i = 0; i < 5; i++) dispatch(7'(10 + i), 32'h400 + 32'(4 * i), 1'b0, 3'(6 + i));
    check("t3_count5", 64'(dut.count), 64'(5));
    check("t3_tail3", 64'(dp_rob_idx), 64'(3));
    check("t3_mis_legal", 64'(empty), 64'(0));
    mispredict = 1'b1; mis_rob_idx = 3'd7;
    wb_valid = 1'b1; wb_rob_idx = 3'd0; wb_data = 32'hEE;
    tick();
    mispredict = 1'b0; wb_valid = 1'b0;
    check("t3_flush_count2", 64'(dut.count), 64'(2));
    check("t3_flush_tail0", 64'(dp_rob_idx), 64'(0));
    check("t3_no_commit", 64'(cm_valid), 64'(0));
    wb(3'd1, 32'h11);
    check("t3_wb_squashed_ignored", 64'(dut.count), 64'(2));
    check("t3_head_not_done", 64'(cm_valid), 64'(0));
    wb(3'd6, 32'h66);
    check("t3_cm6_valid", 64'(cm_valid), 64'(1));
    check("t3_cm6_idx", 64'(cm_rob_idx), 64'(6));
    check("t3_cm6_data", 64'(cm_data), 64'(32'h66));
    wb(3'd7, 32'h77);
    check("t3_cm7_idx", 64'(cm_rob_idx), 64'(7));
    check("t3_cm7_data", 64'(cm_data), 64'(32'h77));
    tick();
    check("t3_empty", 64'(empty), 64'(1));

    // Mispredict with simultaneous dispatch request and head commit
    dispatch(7'd1, 32'h500, 1'b0, 3'd0);
    dispatch(7'd2, 32'h504, 1'b0, 3'd1);
    dispatch(7'd3, 32'h508, 1'b0, 3'd2);
    wb(3'd0, 32'hA5);
    check("t4_head_ready", 64'(cm_valid), 64'(1));
    mispredict = 1'b1; mis_rob_idx = 3'd1;
    dp_valid = 1'b1; dp_rd = 7'd4; dp_pc = 32'h50C; dp_is_store = 1'b0;
    #1;
    check("t4_mis_legal", 64'(empty), 64'(0));
    check("t4_dp_blocked", 64'(dp_ready), 64'(0));
    check("t4_commit_same_cycle", 64'(cm_valid), 64'(1));
    tick();
    mispredict = 1'b0; dp_valid = 1'b0;
    check("t4_count_formula", 64'(dut.count), 64'(1));
    check("t4_tail2", 64'(dp_rob_idx), 64'(2));
    check("t4_not_empty", 64'(empty), 64'(0));
    wb(3'd2, 32'h22);
    check("t4_squashed_wb", 64'(cm_valid), 64'(0));
    wb(3'd1, 32'hB1);
    check("t4_cm1_idx", 64'(cm_rob_idx), 64'(1));
    check("t4_cm1_valid", 64'(cm_valid), 64'(1));
    tick();
    check("t4_empty", 64'(empty), 64'(1));

    // Store completion, both completion ports in one cycle
    dispatch(7'd0, 32'h600, 1'b1, 3'd2);
    dispatch(7'd9, 32'h604, 1'b0, 3'd3);
    st_done_valid = 1'b1; st_done_rob_idx = 3'd2;
    wb_valid = 1'b1; wb_rob_idx = 3'd3; wb_data = 32'hD3;
    #1;
    check("t5_no_bypass", 64'(cm_valid), 64'(0));
    tick();
    st_done_valid = 1'b0; wb_valid = 1'b0;
    check("t5_st_valid", 64'(cm_valid), 64'(1));
    check("t5_st_idx", 64'(cm_rob_idx), 64'(2));
    check("t5_st_is_store", 64'(cm_is_store), 64'(1));
    check("t5_st_data", 64'(cm_data), 64'(0));
    check("t5_st_rd", 64'(cm_rd), 64'(0));
    check("t5_st_pc", 64'(cm_pc), 64'(32'h600));
    tick();
    check("t5_ld_valid", 64'(cm_valid), 64'(1));
    check("t5_ld_idx", 64'(cm_rob_idx), 64'(3));
    check("t5_ld_is_store", 64'(cm_is_store), 64'(0));
    check("t5_ld_data", 64'(cm_data), 64'(32'hD3));
    tick();
    check("t5_empty", 64'(empty), 64'(1));

    // Reset with entries pending and the head committable
    for (int i = 0; i < 4; i++) dispatch(7'(20 + i), 32'h700 + 32'(4 * i), 1'b0, 3'(4 + i));
    check("t6_count4", 64'(dut.count), 64'(4));
    wb(3'd4, 32'h44);
    check("t6_head_ready", 64'(cm_valid), 64'(1));
    do_reset();
    check("t6_empty", 64'(empty), 64'(1));
    check("t6_cm_valid", 64'(cm_valid), 64'(0));
    check("t6_dp_rob_idx", 64'(dp_rob_idx), 64'(0));
    check("t6_count0", 64'(dut.count), 64'(0));

    // Mispredict on the youngest entry flushes nothing
    dispatch(7'd1, 32'h800, 1'b0, 3'd0);
    dispatch(7'd2, 32'h804, 1'b0, 3'd1);
    check("t7_mis_legal", 64'(empty), 64'(0));
    mispredict = 1'b1; mis_rob_idx = 3'd1;
    tick();
    mispredict = 1'b0;
    check("t7_count_kept", 64'(dut.count), 64'(2));
    check("t7_tail_kept", 64'(dp_rob_idx), 64'(2));
    wb(3'd0, 32'h80);
    check("t7_cm0_valid", 64'(cm_valid), 64'(1));
    check("t7_cm0_data", 64'(cm_data), 64'(32'h80));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
